// File: rtl/aes_inv_key_schedule.sv
// rtl/aes_inv_key_schedule.sv - sequential inverse AES-128 key schedule, round 10 back to round 0
module aes_inv_key_schedule #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] last_key_in,
   input  logic         round_ready,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         round_valid,
   output logic         busy,
   output logic         done
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [3:0] NR_IDX = 4'(NR);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   // Rcon for the forward round that produced the current key; index 0 is never used in a step.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   state_t       state_q;
   logic [127:0] key_q;
   logic [127:0] key_d;
   logic [3:0]   idx_q;
   logic         valid_q;
   logic         busy_q;
   logic         done_q;

   logic [31:0]  k0, k1, k2, k3;
   logic [31:0]  n0, n1, n2, n3;
   logic         xfer;

   assign k0 = key_q[127:96];
   assign k1 = key_q[95:64];
   assign k2 = key_q[63:32];
   assign k3 = key_q[31:0];

   assign xfer = valid_q & round_ready;

   // One backward step of the expansion, purely from the key register.
   always_comb begin
      n3    = k3 ^ k2;
      n2    = k2 ^ k1;
      n1    = k1 ^ k0;
      n0    = k0 ^ sub_word({n3[23:0], n3[31:24]}) ^ {rcon(idx_q), 24'h0};
      key_d = {n0, n1, n2, n3};
   end

   // Control FSM with registered key, index and handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         key_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  key_q   <= last_key_in;
                  idx_q   <= NR_IDX;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (xfer) begin
                  if (idx_q == 4'd0) begin
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     key_q <= key_d;
                     idx_q <= idx_q - 4'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign round_key   = key_q;
   assign round_idx   = idx_q;
   assign round_valid = valid_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
- Sequential inverse AES-128 key schedule for the decryption datapath.
- Takes the final (round-10) round key and walks the schedule backwards, one round per accepted handshake.
- Emits round keys 10, 9, … 0 to the inverse-cipher round engine without storing all 44 words.
- It is the read-back counterpart of the forward key expansion: the forward block produces w[0..43] from the cipher key; this block recovers them from w[40..43].

Parameters:
- NR, 10, number of rounds (AES-128 only; other values unsupported).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to load last_key_in; honoured only when busy=0
- last_key_in  input  128  round-10 key; word w40 in [127:96], w43 in [31:0]
- round_ready  input  1  consumer accepts round_key this cycle
- round_key  output  128  current round key, same word packing as last_key_in
- round_idx  output  4  round number of round_key (10 down to 0)
- round_valid  output  1  round_key/round_idx valid
- busy  output  1  schedule in progress
- done  output  1  one-cycle pulse after round 0 accepted

Behaviour:
- Reset (async, rst_n=0):
  - round_key=0, round_idx=0, round_valid=0, busy=0, done=0.
  - State returns to IDLE, including mid-operation; any pending round is discarded.
- States are IDLE and RUN.
- IDLE:
  - start=1 latches last_key_in into the key register and sets round_idx=NR.
  - round_valid=1 and busy=1 from the next cycle (1-cycle latency); state goes to RUN.
  - start=0 holds IDLE with round_valid=0.
- RUN handshake:
  - A transfer occurs on a cycle with round_valid & round_ready.
  - Without a transfer, round_key and round_idx hold stable.
  - round_valid stays high until round 0 is accepted; no gaps between rounds.
- Backward step on transfer with round_idx=r>0 (words k0..k3 = round_key[127:96]..[31:0]):
  - n3 = k3^k2
  - n2 = k2^k1
  - n1 = k1^k0
  - n0 = k0 ^ SubWord(RotWord(n3)) ^ {Rcon(r),24'h0}
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord applies the standard FIPS-197 S-box per byte (256-entry constant table).
  - Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36.
  - Next cycle: round_key={n0,n1,n2,n3}, round_idx=r-1.
- Transfer with round_idx=0:
  - Next cycle: round_valid=0, busy=0, done=1 for exactly one cycle; state goes to IDLE.
  - round_key and round_idx keep their last values.
- Throughput: one round key per cycle with round_ready tied high. 11 keys in 11 cycles after the first valid; done on the 12th.
- start while busy=1 is ignored, with no effect on the sequence.
- start in the same cycle as done is high is accepted (state is already IDLE).
- round_ready while round_valid=0 is ignored.
- Single register stage for the key; the step logic is combinational from the key register. No multicycle paths.

Test Plan:
- FIPS-197 key 2b7e1516…09cf4f3c: start with last_key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, round_ready=1.
  - Required sequence: round_idx=10 d014f9a8…; 9 ac7766f319fadc2128d12941575c006e; … 1 a0fafe1788542cb123a339392a6c7605; 0 2b7e151628aed2a6abf7158809cf4f3c.
  - done pulses one cycle after idx 0.
- FIPS-197 C.1: last_key_in=13111d7fe3944a17f307a78b4d2b30c5 -> idx 0 key = 000102030405060708090a0b0c0d0e0f.
- Backpressure: round_ready toggled randomly (including 5-cycle stalls at idx 10, 5 and 0).
  - round_key/round_idx stable during stalls; same 11-key sequence as the first scenario; no duplicates or drops.
- start asserted at idx 6 with a different key -> ignored; sequence completes with the original key values.
- rst_n pulsed low asynchronously mid-clock at idx 4 -> all outputs 0 immediately.
  - After release, a new start runs the full 11-key sequence from 10.
- Back-to-back: start in the done cycle -> next cycle round_idx=10 with the new key, busy=1.
